// File: rtl/key_debounce_if.sv
// Key conditioning bus: raw buttons in, debounced levels, command pulses and run mode out.
interface key_debounce_if #(
  parameter int NKEYS = 4
) ();
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_level;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_long;
  logic             run_state;

  modport master (
    output key_raw,
    input  key_level, key_press, key_release, key_long, run_state
  );

  modport slave (
    input  key_raw,
    output key_level, key_press, key_release, key_long, run_state
  );
endinterface

// File: rtl/key_debounce_ctrl.sv
// Push-button conditioner: 2-FF sync, shared tick prescaler, per-key debounce,
// press/release/long pulses and a STOP/RUN mode toggled by key 0.
//
//   state   | meaning
//   ST_STOP | run_state = 0, waiting for key_press[0]
//   ST_RUN  | run_state = 1, waiting for key_press[0]
module key_debounce_ctrl #(
  parameter int NKEYS        = 4,
  parameter int TICK_DIV     = 99999,
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000
) (
  input  logic           clk,
  input  logic           reset,
  key_debounce_if.slave  bus
);

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int DW = $clog2(STABLE_TICKS);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST   = DW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [DW-1:0]    r_db_cnt   [NKEYS];
  logic [HW-1:0]    r_hold_cnt [NKEYS];
  logic [NKEYS-1:0] r_level;
  logic [NKEYS-1:0] r_level_q;
  logic [NKEYS-1:0] r_press;
  logic [NKEYS-1:0] r_release;
  logic [NKEYS-1:0] r_long;
  state_t           r_state;
  state_t           w_state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Any agreeing sample restarts the count, so only an unbroken run of
  // STABLE_TICKS differing ticks can move the accepted level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_level[i]  <= ~r_level[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_q <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
      r_release <= ~r_level & r_level_q;
    end
  end

  // Saturating hold counter: the pulse fires only on the step into LONG_TICKS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_long <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_long <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        if (!r_level[i]) begin
          r_hold_cnt[i] <= '0;
        end else if (w_tick && (r_hold_cnt[i] != HOLD_MAX)) begin
          r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
          r_long[i]     <= (r_hold_cnt[i] == HOLD_LAST);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOP: if (r_press[0]) w_state_next = ST_RUN;
      ST_RUN:  if (r_press[0]) w_state_next = ST_STOP;
      default: w_state_next = ST_STOP;
    endcase
  end

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_long    = r_long;
  assign bus.run_state   = (r_state == ST_RUN);

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Bench for key_debounce_ctrl: directed scenarios plus random key activity,
// checked against a tick-arithmetic reference model through a pulse scoreboard.
module tb_key_debounce_ctrl;

  localparam int NK     = 2;
  localparam int TDIV   = 3;
  localparam int STABLE = 4;
  localparam int LONG   = 8;
  localparam int PER    = TDIV + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  key_debounce_if #(.NKEYS(NK)) kif ();

  key_debounce_ctrl #(
    .NKEYS(NK), .TICK_DIV(TDIV), .STABLE_TICKS(STABLE), .LONG_TICKS(LONG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif.slave)
  );

  typedef struct {
    int           cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] lng;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // model state
  int            m_k;
  logic [NK-1:0] m_level, m_raw1, m_raw2, m_pend_rise, m_pend_fall;
  logic          m_run, m_prev_press0;
  int            m_last_agree [NK];
  int            m_rise       [NK];

  // pulse counters observed on the DUT, used by directed checks
  int n_press [NK];
  int n_rel   [NK];
  int n_long  [NK];
  int n_both;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // number of tick edges among clk edges 0..b after reset release
  function automatic int nt(input int b);
    return (b + 1) / PER;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) begin
      n_press[i] = 0;
      n_rel[i]   = 0;
      n_long[i]  = 0;
    end
    n_both = 0;
  endtask

  // Reference model: level flips on the STABLE-th tick since the synced sample
  // last agreed; long fires on the LONG-th tick since the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_k = -1;
        m_level = '0; m_raw1 = '0; m_raw2 = '0;
        m_pend_rise = '0; m_pend_fall = '0;
        m_run = 1'b0; m_prev_press0 = 1'b0;
        for (int i = 0; i < NK; i++) begin
          m_last_agree[i] = -1;
          m_rise[i] = -1;
        end
        exp_q.delete();
      end else begin
        ev_t           ev;
        logic          tick;
        logic [NK-1:0] new_rise, new_fall;
        m_k++;
        if (m_prev_press0) m_run = ~m_run;
        ev.cyc   = m_k;
        ev.press = m_pend_rise;
        ev.rel   = m_pend_fall;
        ev.lng   = '0;
        new_rise = '0;
        new_fall = '0;
        tick = ((m_k % PER) == TDIV);
        for (int i = 0; i < NK; i++) begin
          if (m_level[i] && tick && (nt(m_k) - nt(m_rise[i]) == LONG)) ev.lng[i] = 1'b1;
          if (m_raw2[i] == m_level[i]) begin
            m_last_agree[i] = m_k;
          end else if (tick && (nt(m_k) - nt(m_last_agree[i]) == STABLE)) begin
            m_level[i] = ~m_level[i];
            m_last_agree[i] = m_k;
            if (m_level[i]) begin
              new_rise[i] = 1'b1;
              m_rise[i] = m_k;
            end else begin
              new_fall[i] = 1'b1;
            end
          end
        end
        m_raw2 = m_raw1;
        m_raw1 = kif.key_raw;
        m_pend_rise = new_rise;
        m_pend_fall = new_fall;
        m_prev_press0 = ev.press[0];
        if ((ev.press | ev.rel | ev.lng) != '0) exp_q.push_back(ev);
      end
    end
  end

  // Monitor: compares levels/mode every cycle and pops pulse events from the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("reset_outputs",
              32'({kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.run_state}), 32'd0);
      end else begin
        ev_t exp;
        exp.cyc = m_k; exp.press = '0; exp.rel = '0; exp.lng = '0;
        if (exp_q.size() > 0 && exp_q[0].cyc == m_k) exp = exp_q.pop_front();
        check("key_level", 32'(kif.key_level), 32'(m_level));
        check("run_state", 32'(kif.run_state), 32'(m_run));
        if ((kif.key_press | kif.key_release | kif.key_long | exp.press | exp.rel | exp.lng) != '0)
          check("pulses", 32'({kif.key_press, kif.key_release, kif.key_long}),
                32'({exp.press, exp.rel, exp.lng}));
        for (int i = 0; i < NK; i++) begin
          if (kif.key_press[i])   n_press[i]++;
          if (kif.key_release[i]) n_rel[i]++;
          if (kif.key_long[i])    n_long[i]++;
        end
        if (kif.key_press == 2'b11) n_both++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic run_before;
    clear_counts();
    kif.key_raw = '0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(10);
    check("post_reset_level", 32'(kif.key_level), 32'd0);

    // 1: bounce
    clear_counts();
    for (int t = 0; t < 12; t++) begin
      kif.key_raw[0] = ~kif.key_raw[0];
      idle(5);
    end
    kif.key_raw[0] = 1'b0;
    idle(30);
    check("bounce_pulses", 32'(n_press[0] + n_rel[0] + n_long[0]), 32'd0);
    check("bounce_level", 32'(kif.key_level[0]), 32'd0);

    // 2: clean press
    clear_counts();
    kif.key_raw[0] = 1'b1;
    idle(30);
    check("clean_level", 32'(kif.key_level[0]), 32'd1);
    check("clean_press_cnt", 32'(n_press[0]), 32'd1);
    check("clean_run", 32'(kif.run_state), 32'd1);
    kif.key_raw[0] = 1'b0;
    idle(30);
    check("clean_release_cnt", 32'(n_rel[0]), 32'd1);

    // 3: long hold
    clear_counts();
    kif.key_raw[1] = 1'b1;
    idle(80);
    check("long_press_cnt", 32'(n_press[1]), 32'd1);
    check("long_cnt_held", 32'(n_long[1]), 32'd1);
    kif.key_raw[1] = 1'b0;
    idle(30);
    check("long_release_cnt", 32'(n_rel[1]), 32'd1);
    check("long_cnt_after", 32'(n_long[1]), 32'd1);

    // 4: toggle
    clear_counts();
    run_before = kif.run_state;
    for (int p = 0; p < 2; p++) begin
      kif.key_raw[0] = 1'b1;
      idle(30);
      check("toggle_run", 32'(kif.run_state), 32'(run_before ^ (p == 0)));
      kif.key_raw[0] = 1'b0;
      idle(30);
    end
    kif.key_raw[1] = 1'b1;
    idle(30);
    kif.key_raw[1] = 1'b0;
    idle(30);
    check("toggle_key1_run", 32'(kif.run_state), 32'(run_before));
    check("toggle_press_cnt", 32'(n_press[0]), 32'd2);

    // 5: simultaneous
    clear_counts();
    kif.key_raw = 2'b11;
    idle(30);
    check("simul_both", 32'(n_both), 32'd1);
    kif.key_raw = 2'b00;
    idle(30);
    check("simul_release", 32'(n_rel[0] + n_rel[1]), 32'd2);

    // 6: reset mid-hold
    kif.key_raw[0] = 1'b1;
    idle(30);
    check("prereset_level", 32'(kif.key_level[0]), 32'd1);
    check("prereset_run", 32'(kif.run_state), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_immediate",
          32'({kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.run_state}), 32'd0);
    idle(3);
    reset = 1'b0;
    clear_counts();
    idle(30);
    check("fresh_press", 32'(n_press[0]), 32'd1);
    check("fresh_run", 32'(kif.run_state), 32'd1);
    kif.key_raw = '0;
    idle(30);

    // random activity
    for (int s = 0; s < 150; s++) begin
      kif.key_raw = 2'($urandom_range(0, 3));
      idle($urandom_range(1, 40));
    end
    kif.key_raw = '0;
    idle(60);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
